// File: rtl/switch_input_ctrl_pkg.sv
// Shared definitions for the switch input controller: MMIO read addresses and debounce FSM states.
package switch_input_ctrl_pkg;

   localparam logic [31:0] SW_RAW16    = 32'hFFFF_FFF1;
   localparam logic [31:0] SW_SEXT_HI8 = 32'hFFFF_FFF3;
   localparam logic [31:0] SW_ZEXT_HI8 = 32'hFFFF_FFF5;
   localparam logic [31:0] SW_LOW3     = 32'hFFFF_FFF7;
   localparam logic [31:0] SW_LOW8     = 32'hFFFF_FFFB;
   localparam logic [31:0] SW_STATUS   = 32'hFFFF_FFE1;

   typedef enum logic [1:0] {
      IDLE,
      PRESS_DB,
      HELD,
      REL_DB
   } db_state_e;

   function automatic logic is_data_addr(input logic [31:0] a);
      return (a == SW_RAW16) || (a == SW_SEXT_HI8) || (a == SW_ZEXT_HI8) ||
             (a == SW_LOW3)  || (a == SW_LOW8);
   endfunction

endpackage

// File: rtl/switch_input_ctrl_btn_debounce.sv
// Confirm-button synchroniser and press/release debouncer.
// Emits one registered capture pulse per accepted physical press.
module btn_debounce
   import switch_input_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 20000,
   parameter int CNT_W           = 16
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic btn_i,
   output logic capture_o
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q;
   logic             btn_s_q;
   logic [CNT_W-1:0] cnt_q;
   db_state_e        state_q;
   logic             capture_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync1_q   <= 1'b0;
         btn_s_q   <= 1'b0;
         cnt_q     <= '0;
         state_q   <= IDLE;
         capture_q <= 1'b0;
      end else begin
         sync1_q   <= btn_i;
         btn_s_q   <= sync1_q;
         capture_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (btn_s_q) begin
                  cnt_q   <= '0;
                  state_q <= PRESS_DB;
               end
            end
            PRESS_DB: begin
               if (!btn_s_q) begin
                  state_q <= IDLE;
               end else if (cnt_q == CNT_LAST) begin
                  capture_q <= 1'b1;
                  state_q   <= HELD;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            // Holding never recaptures; only a debounced release re-arms IDLE.
            HELD: begin
               if (!btn_s_q) begin
                  cnt_q   <= '0;
                  state_q <= REL_DB;
               end
            end
            REL_DB: begin
               if (btn_s_q) begin
                  state_q <= HELD;
               end else if (cnt_q == CNT_LAST) begin
                  state_q <= IDLE;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign capture_o = capture_q;

endmodule

// File: rtl/switch_input_ctrl.sv
// MMIO switch input controller: snapshots switches on a debounced confirm press and
// serves formatted reads with 1-cycle latency; status exposes valid/overrun flags.
module switch_input_ctrl
   import switch_input_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 20000,
   parameter int CNT_W           = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        io_rd,
   input  logic [31:0] address,
   input  logic [15:0] switch_input,
   input  logic        confirm_btn,
   output logic [15:0] rdata,
   output logic        data_valid,
   output logic        overrun
);

   logic        capture;
   logic [15:0] snap_q,  snap_d;
   logic [15:0] rdata_q, rdata_d;
   logic        valid_q, valid_d;
   logic        ovr_q,   ovr_d;
   logic        data_rd, stat_rd;

   btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_btn_debounce (
      .clk_i     (clk),
      .rst_i     (rst),
      .btn_i     (confirm_btn),
      .capture_o (capture)
   );

   assign data_rd = io_rd && is_data_addr(address);
   assign stat_rd = io_rd && (address == SW_STATUS);

   always_comb begin
      rdata_d = rdata_q;
      if (io_rd) begin
         case (address)
            SW_RAW16:    rdata_d = snap_q;
            SW_SEXT_HI8: rdata_d = {{8{snap_q[15]}}, snap_q[15:8]};
            SW_ZEXT_HI8: rdata_d = {8'b0, snap_q[15:8]};
            SW_LOW3:     rdata_d = {13'b0, snap_q[2:0]};
            SW_LOW8:     rdata_d = {8'b0, snap_q[7:0]};
            SW_STATUS:   rdata_d = {14'b0, ovr_q, valid_q};
            default:     rdata_d = 16'h0000;
         endcase
      end
   end

   // A capture on the same edge as a read takes priority over the read's flag clear.
   always_comb begin
      snap_d  = snap_q;
      valid_d = valid_q;
      ovr_d   = ovr_q;
      if (capture) begin
         snap_d  = switch_input;
         valid_d = 1'b1;
         if (valid_q) begin
            ovr_d = 1'b1;
         end else if (stat_rd) begin
            ovr_d = 1'b0;
         end
      end else begin
         if (data_rd) valid_d = 1'b0;
         if (stat_rd) ovr_d   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         snap_q  <= '0;
         rdata_q <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         snap_q  <= snap_d;
         rdata_q <= rdata_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
      end
   end

   assign rdata      = rdata_q;
   assign data_valid = valid_q;
   assign overrun    = ovr_q;

endmodule

// File: tb/tb_switch_input_ctrl.sv
// Bench for switch_input_ctrl: directed scenarios plus randomized presses/reads against a flag/snapshot model.
module tb_switch_input_ctrl;

   localparam int DC = 4;
   // Button raised just after edge 0 is seen as a capture on edge DC+4:
   // 2 sync edges, 1 entry edge, DC-1 count edges, 1 registered-pulse edge, 1 load edge.
   localparam int CAP_EDGE = DC + 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        io_rd;
   logic [31:0] address;
   logic [15:0] switch_input;
   logic        confirm_btn;
   logic [15:0] rdata;
   logic        data_valid;
   logic        overrun;

   int n_cmp = 0;
   int n_bad = 0;

   logic [15:0] m_snap;
   logic        m_vld;
   logic        m_ovr;

   always #5 clk = ~clk;

   switch_input_ctrl #(
      .DEBOUNCE_CYCLES (DC),
      .CNT_W           (4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .io_rd        (io_rd),
      .address      (address),
      .switch_input (switch_input),
      .confirm_btn  (confirm_btn),
      .rdata        (rdata),
      .data_valid   (data_valid),
      .overrun      (overrun)
   );

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [15:0] model_fmt(input logic [31:0] a);
      int s;
      s = int'(m_snap);
      case (a)
         32'hFFFF_FFF1: return 16'(s);
         32'hFFFF_FFF3: return 16'((s >= 32768) ? (65280 + s / 256) : (s / 256));
         32'hFFFF_FFF5: return 16'(s / 256);
         32'hFFFF_FFF7: return 16'(s % 8);
         32'hFFFF_FFFB: return 16'(s % 256);
         32'hFFFF_FFE1: return 16'(2 * int'(m_ovr) + int'(m_vld));
         default:       return 16'h0000;
      endcase
   endfunction

   function automatic void model_capture(input logic [15:0] sw);
      if (m_vld) m_ovr = 1'b1;
      m_vld  = 1'b1;
      m_snap = sw;
   endfunction

   function automatic void model_read_fx(input logic [31:0] a);
      if (a == 32'hFFFF_FFF1 || a == 32'hFFFF_FFF3 || a == 32'hFFFF_FFF5 ||
          a == 32'hFFFF_FFF7 || a == 32'hFFFF_FFFB)
         m_vld = 1'b0;
      if (a == 32'hFFFF_FFE1)
         m_ovr = 1'b0;
   endfunction

   task automatic do_read(input logic [31:0] a, output logic [15:0] r);
      io_rd   = 1'b1;
      address = a;
      tick(1);
      io_rd   = 1'b0;
      address = 32'h0;
      r       = rdata;
   endtask

   task automatic press(input logic [15:0] sw, input int hold);
      switch_input = sw;
      confirm_btn  = 1'b1;
      tick(hold);
      confirm_btn  = 1'b0;
      tick(12);
   endtask

   task automatic test_reset;
      rst = 1'b1; io_rd = 1'b0; address = '0; switch_input = '0; confirm_btn = 1'b0;
      tick(3);
      rst = 1'b0;
      m_snap = '0; m_vld = 1'b0; m_ovr = 1'b0;
      n_cmp++; if (rdata !== 16'h0) begin n_bad++; $display("FAIL reset_rdata got %h want 0000", rdata); end
      n_cmp++; if (data_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", data_valid); end
      n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL reset_overrun got %b want 0", overrun); end
   endtask

   task automatic test_capture;
      logic [15:0] r, e;
      press(16'hA5C3, 10);
      model_capture(16'hA5C3);
      n_cmp++; if (data_valid !== m_vld) begin n_bad++; $display("FAIL cap_valid got %b want %b", data_valid, m_vld); end
      e = model_fmt(32'hFFFF_FFF1);
      do_read(32'hFFFF_FFF1, r);
      model_read_fx(32'hFFFF_FFF1);
      n_cmp++; if (r !== e) begin n_bad++; $display("FAIL cap_read got %h want %h", r, e); end
      n_cmp++; if (data_valid !== m_vld) begin n_bad++; $display("FAIL cap_valid_clr got %b want %b", data_valid, m_vld); end
   endtask

   task automatic test_glitch;
      logic [15:0] r, e;
      switch_input = 16'h1111;
      confirm_btn  = 1'b1;
      tick(2);
      confirm_btn  = 1'b0;
      tick(12);
      n_cmp++; if (data_valid !== 1'b0) begin n_bad++; $display("FAIL glitch_valid got %b want 0", data_valid); end
      e = model_fmt(32'hFFFF_FFE1);
      do_read(32'hFFFF_FFE1, r);
      model_read_fx(32'hFFFF_FFE1);
      n_cmp++; if (r !== e) begin n_bad++; $display("FAIL glitch_status got %h want %h", r, e); end
   endtask

   task automatic test_formats;
      logic [31:0] addrs [5];
      logic [15:0] r, e;
      addrs = '{32'hFFFF_FFF3, 32'hFFFF_FFF5, 32'hFFFF_FFFB, 32'hFFFF_FFF7, 32'hFFFF_FFE9};
      press(16'h8F07, 10);
      model_capture(16'h8F07);
      foreach (addrs[i]) begin
         e = model_fmt(addrs[i]);
         do_read(addrs[i], r);
         model_read_fx(addrs[i]);
         n_cmp++; if (r !== e) begin n_bad++; $display("FAIL fmt_%h got %h want %h", addrs[i], r, e); end
      end
   endtask

   task automatic test_overrun;
      logic [15:0] r, e;
      press(16'h8F07, 10);
      model_capture(16'h8F07);
      press(16'h0001, 10);
      model_capture(16'h0001);
      n_cmp++; if (overrun !== m_ovr) begin n_bad++; $display("FAIL ovr_flag got %b want %b", overrun, m_ovr); end
      for (int k = 0; k < 2; k++) begin
         e = model_fmt(32'hFFFF_FFE1);
         do_read(32'hFFFF_FFE1, r);
         model_read_fx(32'hFFFF_FFE1);
         n_cmp++; if (r !== e) begin n_bad++; $display("FAIL ovr_status%0d got %h want %h", k, r, e); end
      end
      e = model_fmt(32'hFFFF_FFF1);
      do_read(32'hFFFF_FFF1, r);
      model_read_fx(32'hFFFF_FFF1);
      n_cmp++; if (r !== e) begin n_bad++; $display("FAIL ovr_data got %h want %h", r, e); end
   endtask

   task automatic test_coincident;
      logic [15:0] r, e;
      press(16'h1234, 10);
      model_capture(16'h1234);
      switch_input = 16'h5678;
      confirm_btn  = 1'b1;
      tick(CAP_EDGE - 1);
      e = model_fmt(32'hFFFF_FFF1);
      io_rd   = 1'b1;
      address = 32'hFFFF_FFF1;
      tick(1);
      io_rd   = 1'b0;
      address = 32'h0;
      model_capture(16'h5678);
      n_cmp++; if (rdata !== e) begin n_bad++; $display("FAIL coin_rdata got %h want %h", rdata, e); end
      n_cmp++; if (data_valid !== m_vld) begin n_bad++; $display("FAIL coin_valid got %b want %b", data_valid, m_vld); end
      tick(3);
      confirm_btn = 1'b0;
      tick(12);
      e = model_fmt(32'hFFFF_FFF1);
      do_read(32'hFFFF_FFF1, r);
      model_read_fx(32'hFFFF_FFF1);
      n_cmp++; if (r !== e) begin n_bad++; $display("FAIL coin_new got %h want %h", r, e); end
      e = model_fmt(32'hFFFF_FFE1);
      do_read(32'hFFFF_FFE1, r);
      model_read_fx(32'hFFFF_FFE1);
      n_cmp++; if (r !== e) begin n_bad++; $display("FAIL coin_status got %h want %h", r, e); end
   endtask

   task automatic test_reset_mid;
      logic [15:0] r, e;
      switch_input = 16'hCAFE;
      confirm_btn  = 1'b1;
      tick(5);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      m_snap = '0; m_vld = 1'b0; m_ovr = 1'b0;
      n_cmp++; if ({rdata, data_valid, overrun} !== 18'h0) begin n_bad++; $display("FAIL rmid_outputs got %h/%b/%b want 0000/0/0", rdata, data_valid, overrun); end
      tick(CAP_EDGE - 1);
      n_cmp++; if (data_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_early got %b want 0", data_valid); end
      tick(1);
      model_capture(16'hCAFE);
      n_cmp++; if (data_valid !== m_vld) begin n_bad++; $display("FAIL rmid_cap got %b want %b", data_valid, m_vld); end
      confirm_btn = 1'b0;
      tick(12);
      e = model_fmt(32'hFFFF_FFF1);
      do_read(32'hFFFF_FFF1, r);
      model_read_fx(32'hFFFF_FFF1);
      n_cmp++; if (r !== e) begin n_bad++; $display("FAIL rmid_data got %h want %h", r, e); end
   endtask

   task automatic test_random;
      logic [31:0] addrs [7];
      logic [31:0] a;
      logic [15:0] sw, r, e;
      for (int it = 0; it < 8; it++) begin
         addrs = '{32'hFFFF_FFF1, 32'hFFFF_FFF3, 32'hFFFF_FFF5, 32'hFFFF_FFF7,
                   32'hFFFF_FFFB, 32'hFFFF_FFE1, ($urandom & 32'h0FFF_FFFF)};
         sw = 16'($urandom);
         press(sw, int'($urandom_range(6, 12)));
         model_capture(sw);
         n_cmp++; if (data_valid !== m_vld) begin n_bad++; $display("FAIL rnd%0d_valid got %b want %b", it, data_valid, m_vld); end
         a = addrs[$urandom_range(0, 6)];
         e = model_fmt(a);
         do_read(a, r);
         model_read_fx(a);
         n_cmp++; if (r !== e) begin n_bad++; $display("FAIL rnd%0d_read %h got %h want %h", it, a, r, e); end
         n_cmp++; if ({overrun, data_valid} !== {m_ovr, m_vld}) begin n_bad++; $display("FAIL rnd%0d_flags got %b%b want %b%b", it, overrun, data_valid, m_ovr, m_vld); end
      end
   endtask

   initial begin
      test_reset;
      test_capture;
      test_glitch;
      test_formats;
      test_overrun;
      test_coincident;
      test_reset_mid;
      test_random;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/switch_input_ctrl.md
Name: switch_input_ctrl

Overview:
- MMIO input controller that sequences user switch entry for the CPU.
- Synchronises and debounces the confirm push-button, snapshots the 16 switches on a confirmed press, and exposes a valid/overrun status word.
- Serves formatted snapshot reads (raw16, sign-ext high8, zero-ext high8, zero-ext low8, low3) on MMIO read strobes.
- Sits between the board switch/button pins and the memory/IO read mux.

Parameters:
- DEBOUNCE_CYCLES, 20000, stable-level cycles required to accept a press or a release (minimum 2).
- CNT_W, 16, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- io_rd  in  1  MMIO read strobe for switch space, one cycle per access
- address  in  32  MMIO address of the access
- switch_input  in  16  raw board switches, quasi-static
- confirm_btn  in  1  raw asynchronous confirm button, high = pressed
- rdata  out  16  registered read data
- data_valid  out  1  unread snapshot present; also drives a board LED
- overrun  out  1  sticky: snapshot replaced while still unread

Behaviour:
- Reset (rst=1 at posedge): rdata=0, data_valid=0, overrun=0, snapshot=0, debounce counter=0, both synchroniser flops=0, FSM=IDLE. A reset issued mid-debounce discards the partial count; no capture results.
- confirm_btn passes through a 2-flop synchroniser to btn_s before any use.
- FSM:
  - IDLE: when btn_s=1, clear the counter and go to PRESS_DB.
  - PRESS_DB: increment the counter while btn_s=1. If btn_s=0 first, return to IDLE with no capture. When the counter reaches DEBOUNCE_CYCLES-1: load snapshot<=switch_input, set data_valid; if data_valid was already 1, also set overrun. Then go to HELD.
  - HELD: when btn_s=0, clear the counter and go to REL_DB.
  - REL_DB: increment the counter while btn_s=0. If btn_s=1 first, return to HELD. When the counter reaches DEBOUNCE_CYCLES-1, go to IDLE.
  - One physical press yields exactly one capture. Holding the button never recaptures.
- Reads: rdata is updated on the posedge where io_rd=1, giving 1-cycle latency. When io_rd=0, rdata holds its value.
  - 0xFFFF_FFF1: snapshot[15:0]
  - 0xFFFF_FFF3: {8{snapshot[15]}, snapshot[15:8]}
  - 0xFFFF_FFF5: {8'b0, snapshot[15:8]}
  - 0xFFFF_FFF7: {13'b0, snapshot[2:0]}
  - 0xFFFF_FFFB: {8'b0, snapshot[7:0]}
  - 0xFFFF_FFE1 (status): {14'b0, overrun, data_valid}; clears overrun on the next edge.
  - Any other address: 16'h0000.
- A data read (any of the five data addresses) clears data_valid on the next edge. If no snapshot is valid, a data read still returns the current snapshot; this is not an error.
- Simultaneous events on one edge:
  - Capture and data read: capture wins. data_valid stays 1, and rdata returns the pre-capture snapshot.
  - Capture and status read: status shows pre-edge values. A new overrun set by the capture wins over the clear.
- Snapshot updates only on capture. Switch changes at any other time are invisible to the CPU.

Decomposition:
- Shared IO package holds:
  - address constants: SW_RAW16, SW_SEXT_HI8, SW_ZEXT_HI8, SW_LOW3, SW_LOW8, SW_STATUS
  - 4-state FSM enum: IDLE, PRESS_DB, HELD, REL_DB
- One natural sub-module, btn_debounce, containing the synchroniser, counter and FSM. It outputs a single-cycle capture pulse. The parent holds the snapshot, flags and read mux.

Test Plan:
- DEBOUNCE_CYCLES=4. Reset, then switches=16'hA5C3, hold button 10 cycles, release, wait 10 cycles -> one capture; data_valid=1; read at FFF1 returns 16'hA5C3 one cycle later; data_valid=0 after that read.
- Glitch: button high for 2 cycles, then low -> no capture; data_valid stays 0; status read returns 16'h0000.
- Format check with snapshot 16'h8F07 -> FFF3 returns FF8F, FFF5 returns 008F, FFFB returns 0007, FFF7 returns 0007, FFE9 returns 0000.
- Two confirmed presses with no data read in between (second with switches=16'h0001) -> overrun=1; status returns 0003; a second status read returns 0001; FFF1 returns 0001.
- Capture edge coincident with an FFF1 read (old snapshot 1234, new 5678) -> rdata=1234, data_valid remains 1, next FFF1 read returns 5678.
- Assert rst during PRESS_DB at count 2, release rst with button still high -> all outputs 0; capture occurs only after 4 fresh stable cycles.
